// File: rtl/sr_mem_pkg.sv
// Shared types for the SR latch write path: FSM state encoding,
// requester identifiers and the request payload carried through arbitration.
package sr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    RECOVER = 2'd2,
    VERIFY  = 2'd3
  } sr_state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Widest latch address the request struct can carry; controller AW must not exceed it.
  localparam int REQ_AW_MAX = 8;

  typedef struct packed {
    logic [REQ_AW_MAX-1:0] addr;
    logic                  val;
  } sr_req_t;

  function automatic sr_req_t make_req(input logic [REQ_AW_MAX-1:0] addr, input logic val);
    sr_req_t r;
    r.addr = addr;
    r.val  = val;
    return r;
  endfunction

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational from the valids and
// the last-served flop; the flop moves only when the owner strobes advance_i
// on an accepted grant.
module sr_rr_arb2
  import sr_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid_a_i,
  input  logic valid_b_i,
  input  logic advance_i,
  output logic grant_a_o,
  output logic grant_b_o
);

  logic last_q;

  // A sole requester always wins; on a tie the side not served last wins.
  always_comb begin
    grant_a_o = valid_a_i && (!valid_b_i || (last_q == REQ_B));
    grant_b_o = valid_b_i && (!valid_a_i || (last_q == REQ_A));
  end

  // Remember who was served; reset points at B so A takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_B;
    end else if (advance_i) begin
      last_q <= grant_b_o ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Write controller for a bank of asynchronous NOR SR latches. Each accepted
// request produces a registered S or R pulse on one latch, a quiet recovery
// gap, a readback of Q, and a one-cycle done/err report.
//
// Handshake: a request transfers on a rising edge where <x>_valid && <x>_ready.
// Ready is combinational, only asserted in IDLE, and never on both sides at once;
// a requester holds valid and payload stable until it sees ready.
module sr_latch_ctrl
  import sr_mem_pkg::*;
#(
  parameter int N_LATCH        = 8,
  parameter int AW             = 3,
  parameter int PULSE_CYCLES   = 2,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [AW-1:0]      a_addr,
  input  logic               a_val,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [AW-1:0]      b_addr,
  input  logic               b_val,
  output logic [N_LATCH-1:0] s_out,
  output logic [N_LATCH-1:0] r_out,
  input  logic [N_LATCH-1:0] q_in,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic               err,
  output logic [1:0]         state_dbg
);

  localparam int CNT_MAX = (PULSE_CYCLES > RECOVER_CYCLES) ? PULSE_CYCLES : RECOVER_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] RECOVER_LAST = CW'(RECOVER_CYCLES - 1);
  localparam logic [REQ_AW_MAX-1:0] N_LIMIT = REQ_AW_MAX'(N_LATCH);

  sr_state_e           state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  sr_req_t             req_q, req_d;
  logic                id_q, id_d;
  logic                bad_q, bad_d;
  logic [N_LATCH-1:0]  s_q, s_d, r_q, r_d;
  logic                done_q, done_d;
  logic                done_id_q, done_id_d;
  logic                err_q, err_d;

  logic                grant_a, grant_b, idle, accept;
  sr_req_t             req_a, req_b, sel_req;
  logic                sel_id;

  // One-hot select of a latch; out-of-range addresses decode to all zero.
  function automatic logic [N_LATCH-1:0] onehot(input logic [REQ_AW_MAX-1:0] a);
    logic [N_LATCH-1:0] v;
    v = '0;
    for (int i = 0; i < N_LATCH; i++) begin
      if (a == REQ_AW_MAX'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  sr_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid_a_i (a_valid),
    .valid_b_i (b_valid),
    .advance_i (accept),
    .grant_a_o (grant_a),
    .grant_b_o (grant_b)
  );

  // Readiness and selection of the winning request payload.
  always_comb begin
    idle    = (state_q == IDLE);
    a_ready = idle && grant_a;
    b_ready = idle && grant_b;
    accept  = a_ready || b_ready;
    req_a   = make_req(REQ_AW_MAX'(a_addr), a_val);
    req_b   = make_req(REQ_AW_MAX'(b_addr), b_val);
    sel_req = grant_b ? req_b : req_a;
    sel_id  = grant_b ? REQ_B : REQ_A;
  end

  // Next-state logic: FSM, cycle counter and registered S/R drive.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    id_d      = id_q;
    bad_d     = bad_q;
    s_d       = '0;
    r_d       = '0;
    done_d    = 1'b0;
    done_id_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = sel_req;
          id_d  = sel_id;
          cnt_d = '0;
          bad_d = !(sel_req.addr < N_LIMIT);
          if (sel_req.addr < N_LIMIT) begin
            // S/R come up together with the PULSE state so no input reaches them combinationally.
            state_d = PULSE;
            s_d     = sel_req.val ? onehot(sel_req.addr) : '0;
            r_d     = sel_req.val ? '0 : onehot(sel_req.addr);
          end else begin
            state_d = VERIFY;
          end
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
          s_d   = s_q;
          r_d   = r_q;
        end
      end
      RECOVER: begin
        if (cnt_q == RECOVER_LAST) begin
          cnt_d   = '0;
          state_d = VERIFY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      VERIFY: begin
        done_d    = 1'b1;
        done_id_d = id_q;
        err_d     = bad_q || ((|(q_in & onehot(req_q.addr))) != req_q.val);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any pulse in flight without reporting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      id_q      <= REQ_A;
      bad_q     <= 1'b0;
      s_q       <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      id_q      <= id_d;
      bad_q     <= bad_d;
      s_q       <= s_d;
      r_q       <= r_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
    end
  end

  // Latch-safety invariants: never S and R together, at most one latch driven, quiet outside PULSE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((s_q & r_q) == '0);
      assert ($countones(s_q | r_q) <= 1);
      assert ((state_q == PULSE) || ((s_q | r_q) == '0));
    end
  end

  assign s_out     = s_q;
  assign r_out     = r_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: an 8-latch controller wired to a behavioural
// latch bank, plus a 6-latch instance for out-of-range addresses.
module tb_sr_latch_ctrl;

  localparam int P = 2;
  localparam int R = 1;
  localparam int LAT_OK  = P + R + 2;
  localparam int LAT_BAD = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT signals
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic [2:0] a_addr = '0, b_addr = '0;
  logic       a_val = 1'b0, b_val = 1'b0;
  logic [7:0] s_out, r_out, q_in;
  logic       busy, done, done_id, err;
  logic [1:0] state_dbg;

  // Six-latch DUT signals
  logic       c_a_valid = 1'b0, c_b_valid = 1'b0;
  logic       c_a_ready, c_b_ready;
  logic [2:0] c_a_addr = '0, c_b_addr = '0;
  logic       c_a_val = 1'b0, c_b_val = 1'b0;
  logic [5:0] c_s_out, c_r_out;
  logic [5:0] c_q_in = '0;
  logic       c_busy, c_done, c_done_id, c_err;
  logic [1:0] c_state_dbg;

  // Behavioural latch bank: Q sets on S, clears on R; force_mask pins Q low for fault injection.
  logic [7:0] lq = '0;
  logic [7:0] force_mask = '0;
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (s_out[i])      lq[i] <= 1'b1;
      else if (r_out[i]) lq[i] <= 1'b0;
    end
  end
  assign q_in = lq & ~force_mask;

  sr_latch_ctrl #(.N_LATCH(8), .AW(3), .PULSE_CYCLES(P), .RECOVER_CYCLES(R)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_val(a_val),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_val(b_val),
    .s_out(s_out), .r_out(r_out), .q_in(q_in),
    .busy(busy), .done(done), .done_id(done_id), .err(err), .state_dbg(state_dbg)
  );

  sr_latch_ctrl #(.N_LATCH(6), .AW(3), .PULSE_CYCLES(P), .RECOVER_CYCLES(R)) u_bad (
    .clk(clk), .rst(rst),
    .a_valid(c_a_valid), .a_ready(c_a_ready), .a_addr(c_a_addr), .a_val(c_a_val),
    .b_valid(c_b_valid), .b_ready(c_b_ready), .b_addr(c_b_addr), .b_val(c_b_val),
    .s_out(c_s_out), .r_out(c_r_out), .q_in(c_q_in),
    .busy(c_busy), .done(c_done), .done_id(c_done_id), .err(c_err), .state_dbg(c_state_dbg)
  );

  // Scoreboard counters and reference model state
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   lm [8];          // expected latch contents
  logic last_m = 1'b1;   // expected last-served requester (1 = B)
  int   acc_q[$];        // cycle numbers of accepts
  logic [0:0] id_obs_q[$];
  logic last_err, last_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every-cycle latch safety on the main DUT
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_s_and_r", 32'(s_out & r_out), 32'd0);
      check("inv_one_active", 32'($countones(s_out | r_out) <= 1), 32'd1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_m = 1'b1;
  endtask

  // Driver + model for one transfer: caller has set valids/payloads at a negedge.
  task automatic serve(input string tag);
    logic       win, v, qb, err_exp;
    logic [2:0] ad;
    logic [7:0] pm, s_exp, r_exp;
    bit         seen;
    #1;
    win = (a_valid && b_valid) ? ~last_m : b_valid;
    check({tag, "_a_ready"}, 32'(a_ready), 32'(!win));
    check({tag, "_b_ready"}, 32'(b_ready), 32'(win));
    acc_q.push_back(cyc);
    ad = win ? b_addr : a_addr;
    v  = win ? b_val : a_val;
    @(negedge clk);
    if (win) b_valid = 1'b0; else a_valid = 1'b0;
    last_m  = win;
    lm[ad]  = v;
    qb      = lm[ad] & ~force_mask[ad];
    err_exp = (qb != v);
    pm      = 8'd1 << ad;
    seen    = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      s_exp = (k <= P && v)  ? pm : 8'd0;
      r_exp = (k <= P && !v) ? pm : 8'd0;
      check({tag, "_s_out"}, 32'(s_out), 32'(s_exp));
      check({tag, "_r_out"}, 32'(r_out), 32'(r_exp));
      check({tag, "_busy"}, 32'(busy), 32'(k < LAT_OK));
      if (done === 1'b1) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(k), 32'(LAT_OK));
        check({tag, "_done_id"}, 32'(done_id), 32'(win));
        check({tag, "_err"}, 32'(err), 32'(err_exp));
        last_err = err;
        last_id  = done_id;
        id_obs_q.push_back(done_id);
        break;
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  // Out-of-range and in-range operations on the six-latch instance
  task automatic serve_c(input string tag, input logic [2:0] ad, input logic v);
    logic bad;
    bit   seen;
    logic [5:0] pm;
    bad = (ad >= 3'd6);
    pm  = bad ? 6'd0 : (6'd1 << ad);
    c_a_valid = 1'b1; c_a_addr = ad; c_a_val = v;
    #1;
    check({tag, "_ready"}, 32'(c_a_ready), 32'd1);
    @(negedge clk);
    c_a_valid = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      check({tag, "_s_out"}, 32'(c_s_out), 32'((k <= P && !bad && v) ? pm : 6'd0));
      check({tag, "_r_out"}, 32'(c_r_out), 32'((k <= P && !bad && !v) ? pm : 6'd0));
      if (c_done === 1'b1) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(k), 32'(bad ? LAT_BAD : LAT_OK));
        check({tag, "_err"}, 32'(c_err), 32'(bad || v));  // q tied low
        check({tag, "_done_id"}, 32'(c_done_id), 32'd0);
        break;
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_s_out", 32'(s_out), 32'd0);
    check("rst_r_out", 32'(r_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_c_busy", 32'(c_busy), 32'd0);

    // Single set on latch 3
    @(negedge clk);
    a_valid = 1'b1; a_addr = 3'd3; a_val = 1'b1;
    serve("single_set");
    check("single_set_q3", 32'(q_in[3]), 32'd1);

    // Tie arbitration from a fresh reset
    do_reset();
    id_obs_q.delete();
    a_valid = 1'b1; a_addr = 3'd1; a_val = 1'b1;
    b_valid = 1'b1; b_addr = 3'd2; b_val = 1'b0;
    serve("tie1");
    a_valid = 1'b1; a_addr = 3'd1; a_val = 1'b0;
    serve("tie2");
    b_valid = 1'b1; b_addr = 3'd2; b_val = 1'b1;
    serve("tie3");
    serve("tie4");
    check("tie_seq_len", 32'(id_obs_q.size()), 32'd4);
    if (id_obs_q.size() == 4) begin
      check("tie_seq0", 32'(id_obs_q[0]), 32'd0);
      check("tie_seq1", 32'(id_obs_q[1]), 32'd1);
      check("tie_seq2", 32'(id_obs_q[2]), 32'd0);
      check("tie_seq3", 32'(id_obs_q[3]), 32'd1);
    end

    // Readback fault: Q5 pinned low while B sets latch 5
    force_mask = 8'h20;
    b_valid = 1'b1; b_addr = 3'd5; b_val = 1'b1;
    serve("rb_fault");
    check("rb_fault_err", 32'(last_err), 32'd1);
    check("rb_fault_id", 32'(last_id), 32'd1);
    @(negedge clk);
    force_mask = 8'h00;

    // Bad addresses on the six-latch instance, then a good one
    serve_c("bad7", 3'd7, 1'b1);
    @(negedge clk);
    serve_c("bad6", 3'd6, 1'b0);
    @(negedge clk);
    serve_c("good5", 3'd5, 1'b0);

    // Reset during the first PULSE cycle
    @(negedge clk);
    a_valid = 1'b1; a_addr = 3'd4; a_val = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    check("midrst_pulse", 32'(s_out), 32'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_m = 1'b1;
    lm[4] = 1'b1;
    check("midrst_s_out", 32'(s_out), 32'd0);
    check("midrst_r_out", 32'(r_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("midrst_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    b_valid = 1'b1; b_addr = 3'd4; b_val = 1'b0;
    a_valid = 1'b1; a_addr = 3'd6; a_val = 1'b1;
    serve("after_rst1");   // tie after reset: A wins again
    serve("after_rst2");

    // Back-to-back clears with A's valid never dropping between transfers
    acc_q.delete();
    for (int n = 0; n < 4; n++) begin
      a_valid = 1'b1; a_addr = 3'($urandom_range(0, 7)); a_val = 1'b0;
      serve("b2b");
    end
    check("b2b_accepts", 32'(acc_q.size()), 32'd4);
    for (int n = 0; n + 1 < acc_q.size(); n++)
      check("b2b_spacing", 32'(acc_q[n+1] - acc_q[n]), 32'(LAT_OK));

    // Randomized traffic from both requesters
    for (int it = 0; it < 40; it++) begin
      if (!a_valid && !b_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (!a_valid && $urandom_range(0, 1) == 1) begin
        a_valid = 1'b1; a_addr = 3'($urandom_range(0, 7)); a_val = 1'($urandom_range(0, 1));
      end
      if (!b_valid && $urandom_range(0, 1) == 1) begin
        b_valid = 1'b1; b_addr = 3'($urandom_range(0, 7)); b_val = 1'($urandom_range(0, 1));
      end
      if (!a_valid && !b_valid) begin
        a_valid = 1'b1; a_addr = 3'($urandom_range(0, 7)); a_val = 1'($urandom_range(0, 1));
      end
      force_mask = ($urandom_range(0, 3) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
      serve("rand");
    end
    while (a_valid || b_valid) serve("drain");
    force_mask = 8'd0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
